// File: rtl/imem_loader.sv
// Byte-serial instruction loader: assembles little-endian words from a valid/ready
// stream, parses a {base, count} header and emits one memory write per payload word.
module imem_loader #(
    parameter int ADDRSIZE = 256,
    parameter int BITWIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BITWIDTH-1:0] write_addr,
    output logic [BITWIDTH-1:0] write_data,
    output logic                write_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int NB = BITWIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0]       LAST  = BW'(NB - 1);
    localparam logic [BITWIDTH-1:0] DEPTH = BITWIDTH'(ADDRSIZE);

    typedef enum logic [1:0] {HDR_ADDR, HDR_LEN, DATA, DONE} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [BITWIDTH-1:0] asm_q, asm_d;
    logic [BITWIDTH-1:0] base_q, base_d;
    logic [BITWIDTH-1:0] addr_q, addr_d;
    logic [BITWIDTH-1:0] rem_q, rem_d;
    logic                in_ready_q, in_ready_d;
    logic                wv_q, wv_d;
    logic [BITWIDTH-1:0] waddr_q, waddr_d;
    logic [BITWIDTH-1:0] wdata_q, wdata_d;
    logic                err_q, err_d;

    logic [BITWIDTH-1:0] word_c;
    logic                accept;
    logic                word_done;

    // Assembly register with the incoming byte merged into its slot.
    always_comb begin
        word_c = asm_q;
        word_c[{bcnt_q, 3'b000} +: 8] = in_data;
    end

    assign accept    = in_valid && in_ready_q;
    assign word_done = accept && (bcnt_q == LAST);

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        base_d  = base_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wv_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        if (accept) begin
            asm_d  = word_c;
            bcnt_d = word_done ? '0 : bcnt_q + 1'b1;
        end

        case (state_q)
            HDR_ADDR: begin
                if (word_done) begin
                    base_d  = word_c;
                    err_d   = 1'b0;
                    state_d = HDR_LEN;
                end
            end
            HDR_LEN: begin
                if (word_done) begin
                    rem_d   = word_c;
                    addr_d  = base_q;
                    state_d = (word_c == '0) ? DONE : DATA;
                end
            end
            DATA: begin
                // remaining==0 is the strobe cycle of the last word; done follows it.
                // A byte taken here starts the next header (BITWIDTH >= 16 assumed).
                if (rem_q == '0) begin
                    state_d = DONE;
                end else if (word_done) begin
                    waddr_d = addr_q;
                    wdata_d = word_c;
                    if ((addr_q >> 2) < DEPTH) wv_d  = 1'b1;
                    else                       err_d = 1'b1;
                    addr_d = addr_q + BITWIDTH'(4);
                    rem_d  = rem_q - 1'b1;
                end
            end
            DONE:    state_d = HDR_ADDR;
            default: state_d = HDR_ADDR;
        endcase

        in_ready_d = (state_d != DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= HDR_ADDR;
            bcnt_q     <= '0;
            asm_q      <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            in_ready_q <= 1'b0;
            wv_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            asm_q      <= asm_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            in_ready_q <= in_ready_d;
            wv_q       <= wv_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign write_valid = wv_q;
    assign write_addr  = waddr_q;
    assign write_data  = wdata_q;
    assign err         = err_q;
    assign done        = (state_q == DONE);
    assign busy        = (state_q != HDR_ADDR) || (bcnt_q != '0);

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized loads checked against a list-based model of the expected writes.
module tb_imem_loader;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        write_valid;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.ADDRSIZE(256), .BITWIDTH(32)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .write_addr(write_addr), .write_data(write_data),
        .write_valid(write_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Observed activity, sampled mid-cycle.
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] pay[$];
    int  last_wv_cyc, done_cnt = 0, done_cyc, last_acc_cyc;
    logic err_at_done, rdy_at_done;
    int  rdy_low = 0, busy_low = 0;
    bit  mon_en = 0, in_load = 0;

    always @(negedge clock) begin
        if (!reset && mon_en) begin
            if (write_valid) begin
                wa_q.push_back(write_addr);
                wd_q.push_back(write_data);
                last_wv_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                err_at_done = err;
                rdy_at_done = in_ready;
            end
            if (!in_ready && !done) rdy_low++;
            if (in_load && !busy) busy_low++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(negedge clock);
        last_acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int stall_byte, input int stall_len);
        logic [31:0] v;
        v = w;
        for (int k = 0; k < 4; k++) begin
            if (k == stall_byte) repeat (stall_len) @(negedge clock);
            send_byte(v[8*k +: 8]);
        end
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clock);
            t++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        #1;
    endtask

    // Payload comes from pay[]; stall applies inside payload word stall_w.
    task automatic run_load(input logic [31:0] base, input int stall_w, input int stall_b,
                            input int stall_len);
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        logic [31:0] a;
        logic        exp_err;
        bit          last_in_range;
        int          dc0, n;
        n = pay.size();
        wa_q.delete();
        wd_q.delete();
        dc0 = done_cnt;
        exp_err = 1'b0;
        last_in_range = 0;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            if ((a >> 2) < 256) begin
                ea.push_back(a);
                ed.push_back(pay[i]);
                last_in_range = (i == n - 1);
            end else begin
                exp_err = 1'b1;
            end
        end

        send_word(base, -1, 0);
        in_load = 1;
        check("err_clear_on_base", err, 1'b0);
        send_word(32'(n), -1, 0);
        for (int i = 0; i < n; i++)
            send_word(pay[i], (i == stall_w) ? stall_b : -1, stall_len);
        wait_done(100);
        in_load = 0;

        check("nwrites", wa_q.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
            check("waddr", wa_q[i], ea[i]);
            check("wdata", wd_q[i], ed[i]);
        end
        check("done_cnt", done_cnt - dc0, 1);
        check("done_lat", done_cyc, (n == 0) ? last_acc_cyc : last_acc_cyc + 1);
        check("err_at_done", err_at_done, exp_err);
        check("rdy_at_done", rdy_at_done, 1'b0);
        if (last_in_range) check("wv_lat", last_wv_cyc, last_acc_cyc);
    endtask

    initial begin
        int dc0;
        logic [31:0] base;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clock);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_wv", write_valid, 1'b0);
        check("rst_waddr", write_addr, 32'h0);
        check("rst_wdata", write_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("rdy_after_rst", in_ready, 1'b1);
        mon_en = 1;

        // Basic load
        pay = '{32'h11111111, 32'h22222222, 32'h33333333};
        run_load(32'h10, -1, 0, 0);
        // Byte order: bytes 78 56 34 12
        pay = '{32'h12345678};
        run_load(32'h20, -1, 0, 0);
        // Zero length
        pay.delete();
        run_load(32'h0, -1, 0, 0);
        // Range and stall: third word lands at 0x400
        pay = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
        run_load(32'h3F8, 1, 2, 5);
        repeat (2) @(negedge clock);
        check("err_sticky_idle", err, 1'b1);
        check("busy_idle", busy, 1'b0);
        // Address wrap: 0xFFFFFFFC dropped, 0x0 written
        pay = '{32'hDEADBEEF, 32'hCAFEF00D};
        run_load(32'hFFFF_FFFC, -1, 0, 0);

        // Reset mid-load, after 2 of 4 bytes of the second payload word
        wa_q.delete();
        wd_q.delete();
        dc0 = done_cnt;
        send_word(32'h40, -1, 0);
        send_word(32'd3, -1, 0);
        send_word(32'h5555AAAA, -1, 0);
        send_byte(8'h01);
        send_byte(8'h02);
        #2;
        mon_en = 0;
        reset  = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_wv", write_valid, 1'b0);
        check("mid_rst_waddr", write_addr, 32'h0);
        check("mid_rst_wdata", write_data, 32'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        mon_en = 1;
        repeat (3) @(negedge clock);
        check("rst_nwrites", wa_q.size(), 1);
        check("rst_no_done", done_cnt - dc0, 0);
        pay = '{32'h01020304, 32'h0A0B0C0D};
        run_load(32'h80, 0, 1, 2);

        // Randomized loads, biased toward the top of memory
        for (int r = 0; r < 8; r++) begin
            pay.delete();
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) pay.push_back($urandom);
            if ($urandom_range(0, 1) == 1) base = 32'h3F0 + 32'(4 * $urandom_range(0, 4));
            else                           base = 32'($urandom_range(0, 255)) << 2;
            run_load(base, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        check("in_ready_low_outside_done", rdy_low, 0);
        check("busy_low_during_load", busy_low, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
